quad_decoder: RTL and testbench
===============================

# quad_decoder

Parametrised quadrature decoder, the next generation of the rotary-encoder front end. It synchronises and debounces the A/B encoder pins, then decodes them in a selectable x1/x2/x4 mode. It drives a WIDTH-bit position counter that either wraps modulo MAX_COUNT+1 (detent counting) or saturates. It also provides a direction flag, a per-step strobe, a sticky illegal-transition error and a synchronous preset load. It sits between the encoder pins and the user-register logic.

## Interface
- WIDTH, 8: counter width in bits, 2..32.
- MAX_COUNT, 2**WIDTH-1: upper count limit, at most 2**WIDTH-1.
- DB_CYCLES, 16: stable cycles required before a filtered pin changes, at least 1.
- SATURATE, 0: 0 means wrap between 0 and MAX_COUNT; 1 means clamp at 0 and MAX_COUNT.
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- in_a, in_b  in  1  raw encoder pins, asynchronous to clk.
- mode  in  2  decode mode: 00 or 01 = x1, 10 = x2, 11 = x4.
- load_en  in  1  when high, loads load_val this cycle.
- load_val  in  WIDTH  preset value.
- clr_err  in  1  clears err.
- count  out  WIDTH  position counter.
- step  out  1  one-cycle pulse on every count change caused by the encoder.
- dir  out  1  direction of the last counted step (1 = up); held between steps.
- err  out  1  sticky illegal-transition flag.
- a_db, b_db  out  1  filtered pin levels.

## Operation
- Synchroniser: a 2-FF synchroniser per pin; both stages reset to 0.
- Priming: for the first 3 cycles after reset release, a_db/b_db copy the synchroniser outputs directly. During priming nothing is counted and no error is flagged. This stops a detent resting at 11 from registering as a transition.
- Debounce, per pin, after priming:
  - A counter increments while the sync output differs from the filtered level.
  - The counter clears whenever the two are equal.
  - When the counter reaches DB_CYCLES, the filtered level takes the sync value and the counter clears.
- Transitions: evaluated on each cycle where {a_db,b_db} differs from its value one cycle earlier (prev).
  - Up sequence: 00→10→11→01→00.
  - Down sequence: the reverse.
  - Illegal: both bits change in the same cycle.
- Counting per mode:
  - x1: rising A only. 00→10 counts up; 01→11 counts down.
  - x2: any A edge. Direction is up when, after the edge, A≠B; down when A=B.
  - x4: every legal transition counts.
  - Transitions not selected by the mode are ignored: no step, dir unchanged.
- Counter arithmetic:
  - Up at MAX_COUNT gives 0 when wrapping, or holds at MAX_COUNT when saturating.
  - Down at 0 gives MAX_COUNT when wrapping, or holds at 0 when saturating.
  - A saturated hold still pulses step and updates dir.
- Load:
  - load_en has priority over an encoder step in the same cycle. The step is dropped: no step pulse, dir unchanged.
  - A load_val above MAX_COUNT loads MAX_COUNT.
- Error:
  - An illegal transition sets err and does not count.
  - clr_err clears err.
  - If an illegal transition and clr_err occur in the same cycle, err ends up set.
- mode may change at any time and takes effect from the next evaluated transition; count is not altered.
- Reset values:
  - count = 0, step = 0, dir = 1, err = 0, a_db = b_db = 0.
  - Debounce counters, prev and the priming counter all reset to 0.
- Reset asserted mid-debounce or mid-step discards all pending state immediately.

## Timing
- Pin to filtered latency: a pin level first sampled at edge k, and held stable, appears on a_db/b_db at edge k+2+DB_CYCLES.
- Filtered to count latency: count, step and dir update at the edge after a_db/b_db change. Total pin-to-count latency is 3+DB_CYCLES edges.
- Glitch rejection: a glitch shorter than DB_CYCLES cycles at the sync output never reaches a_db/b_db.
- step width: exactly one cycle per counted transition. Back-to-back steps on consecutive cycles are possible only if the filtered pins change on consecutive cycles.
- load_en: count equals load_val at the edge after load_en is sampled high.
- err: sets at the same edge a count would have updated. clr_err takes effect one edge after it is sampled.

## Test plan
- Up counting (WIDTH=8, DB_CYCLES=4, mode=x4): drive 3 full up cycles (12 transitions), each level held 10 cycles → count=12, 12 step pulses, dir=1, each count update 7 edges after the pin change.
- Mode and direction (mode=x1): 2 full down cycles → count=254 (wrap from 0), 2 step pulses. Repeat in x2 → count drops by 4.
- Wrap and saturate (MAX_COUNT=23):
  - SATURATE=0: load 23, then one x4 up → count=0.
  - SATURATE=1: load 23, then up → count=23 and step pulses. Load 0, then down → count stays 0.
- Glitch rejection (DB_CYCLES=8): a 5-cycle pulse on in_a → a_db and count unchanged. A 9-cycle pulse → a_db toggles.
- Illegal transition and error clear: force a_db/b_db 00→11 by changing both pins in the same cycle → err=1, count unchanged. clr_err → err=0. Assert clr_err together with another illegal transition → err=1.
- Reset and priming: hold the pins at 11 through reset release → no step, no err, a_db=b_db=1 after 3 cycles. Assert load_en together with a step → count=load_val, no step. Assert rstn mid-sequence → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/quad_decoder_if.sv
// Bundle of the encoder-facing and user-facing signals of the quadrature decoder.
// The master side is whatever drives the pins and user controls; the slave side
// is the decoder itself.
interface quad_decoder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_a;
   logic             in_b;
   logic [1:0]       mode;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic             clr_err;
   logic [WIDTH-1:0] count;
   logic             step;
   logic             dir;
   logic             err;
   logic             a_db;
   logic             b_db;

   modport master (
      output in_a, in_b, mode, load_en, load_val, clr_err,
      input  count, step, dir, err, a_db, b_db
   );

   modport slave (
      input  in_a, in_b, mode, load_en, load_val, clr_err,
      output count, step, dir, err, a_db, b_db
   );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and debounces the A/B pins, decodes them in
// x1/x2/x4 mode and drives a wrapping or saturating position counter with
// step strobe, direction flag, sticky illegal-transition error and preset load.
// Pin pairs are carried as {A,B} two-bit vectors throughout.
module quad_decoder #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter int unsigned      DB_CYCLES = 16,
   parameter bit               SATURATE  = 1'b0
) (
   input logic           clk,
   input logic           rstn,
   quad_decoder_if.slave bus
);

   localparam int unsigned    DBW      = $clog2(DB_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LIMIT = DBW'(DB_CYCLES);

   // Three priming cycles after reset, then normal running
   typedef enum logic [1:0] {PRIME0, PRIME1, PRIME2, RUN} phase_t;

   phase_t                 phase_q, phase_d;
   logic [1:0]             sync1_q, sync2_q;
   logic [1:0]             filt_q, filt_d;
   logic [1:0]             prev_q, prev_d;
   logic [1:0][DBW-1:0]    dbCnt_q, dbCnt_d;
   logic [WIDTH-1:0]       count_q, count_d;
   logic                   step_q, step_d;
   logic                   dir_q, dir_d;
   logic                   err_q, err_d;

   logic                   aEdge, bEdge, illegal, moveUp, selected;
   logic [WIDTH-1:0]       countUp, countDown;

   assign aEdge   = filt_q[1] ^ prev_q[1];
   assign bEdge   = filt_q[0] ^ prev_q[0];
   assign illegal = aEdge & bEdge;
   // After an A edge the move is up when A differs from B; after a B edge it is up when they match
   assign moveUp  = aEdge ? (filt_q[1] ^ filt_q[0]) : ~(filt_q[1] ^ filt_q[0]);

   assign countUp   = (count_q == MAX_COUNT) ? (SATURATE ? MAX_COUNT : '0) : count_q + 1'b1;
   assign countDown = (count_q == '0) ? (SATURATE ? '0 : MAX_COUNT) : count_q - 1'b1;

   // Decide whether the current filtered transition is one the selected mode counts
   always_comb begin
      selected = 1'b0;
      if (!illegal) begin
         case (bus.mode)
            2'b11:   selected = aEdge | bEdge;
            2'b10:   selected = aEdge;
            default: selected = aEdge & filt_q[1];
         endcase
      end
   end

   // Next-state logic: priming, per-pin debounce, transition counting, load and error
   always_comb begin
      phase_d = phase_q;
      filt_d  = filt_q;
      prev_d  = filt_q;
      dbCnt_d = dbCnt_q;
      count_d = count_q;
      step_d  = 1'b0;
      dir_d   = dir_q;
      err_d   = err_q & ~bus.clr_err;

      if (phase_q != RUN) begin
         filt_d  = sync2_q;
         prev_d  = sync2_q;
         dbCnt_d = '0;
         case (phase_q)
            PRIME0:  phase_d = PRIME1;
            PRIME1:  phase_d = PRIME2;
            default: phase_d = RUN;
         endcase
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               dbCnt_d[i] = '0;
            end else if (dbCnt_q[i] == DB_LIMIT) begin
               filt_d[i]  = sync2_q[i];
               dbCnt_d[i] = '0;
            end else begin
               dbCnt_d[i] = dbCnt_q[i] + 1'b1;
            end
         end

         if (illegal) begin
            err_d = 1'b1;
         end else if (selected && !bus.load_en) begin
            step_d  = 1'b1;
            dir_d   = moveUp;
            count_d = moveUp ? countUp : countDown;
         end
      end

      if (bus.load_en) begin
         count_d = (bus.load_val > MAX_COUNT) ? MAX_COUNT : bus.load_val;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_q <= PRIME0;
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
         prev_q  <= '0;
         dbCnt_q <= '0;
         count_q <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         sync1_q <= {bus.in_a, bus.in_b};
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         prev_q  <= prev_d;
         dbCnt_q <= dbCnt_d;
         count_q <= count_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   assign bus.count = count_q;
   assign bus.step  = step_q;
   assign bus.dir   = dir_q;
   assign bus.err   = err_q;
   assign bus.a_db  = filt_q[1];
   assign bus.b_db  = filt_q[0];

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder. Two instances share one stimulus:
// dut0 wraps over 0..255, dut1 saturates over 0..23. Both debounce for 4 cycles.
module tb_quad_decoder;

   localparam int DB   = 4;
   localparam int HOLD = 10;
   localparam int MAX0 = 255;
   localparam int MAX1 = 23;

   logic       clk;
   logic       rstn;
   logic       pinA, pinB;
   logic [1:0] modeV;
   logic       loadEn;
   logic [7:0] loadVal;
   logic       clrErr;

   quad_decoder_if #(.WIDTH(8)) bus0 ();
   quad_decoder_if #(.WIDTH(5)) bus1 ();

   assign bus0.in_a     = pinA;
   assign bus0.in_b     = pinB;
   assign bus0.mode     = modeV;
   assign bus0.load_en  = loadEn;
   assign bus0.load_val = loadVal;
   assign bus0.clr_err  = clrErr;
   assign bus1.in_a     = pinA;
   assign bus1.in_b     = pinB;
   assign bus1.mode     = modeV;
   assign bus1.load_en  = loadEn;
   assign bus1.load_val = loadVal[4:0];
   assign bus1.clr_err  = clrErr;

   quad_decoder #(.WIDTH(8), .MAX_COUNT(8'd255), .DB_CYCLES(DB), .SATURATE(1'b0)) dut0 (
      .clk(clk), .rstn(rstn), .bus(bus0)
   );

   quad_decoder #(.WIDTH(5), .MAX_COUNT(5'd23), .DB_CYCLES(DB), .SATURATE(1'b1)) dut1 (
      .clk(clk), .rstn(rstn), .bus(bus1)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] ab;
      logic [1:0] md;
      int         cnt;
      bit         dirE;
      int         stepsE;
   } vec_t;

   vec_t       vecs[$];
   int         total = 0;
   int         bad   = 0;
   int         steps0, steps1, cycIdx, firstChg, lastCnt0;
   bit         aHigh;
   logic [1:0] curAb;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic startWindow();
      steps0   = 0;
      steps1   = 0;
      aHigh    = 1'b0;
      cycIdx   = 0;
      firstChg = -1;
      lastCnt0 = int'(bus0.count);
   endtask

   task automatic applyStimulus(input logic [1:0] ab, input logic [1:0] md);
      pinA  = ab[1];
      pinB  = ab[0];
      modeV = md;
      curAb = ab;
      startWindow();
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus0.step) steps0++;
      if (bus1.step) steps1++;
      if (bus0.a_db) aHigh = 1'b1;
      if (int'(bus0.count) != lastCnt0 && firstChg < 0) firstChg = cycIdx;
      lastCnt0 = int'(bus0.count);
      cycIdx++;
   endtask

   function automatic void addVec(input logic [1:0] ab, input logic [1:0] md,
                                  input int cnt, input bit dirE, input int stepsE);
      vec_t v;
      v.ab = ab; v.md = md; v.cnt = cnt; v.dirE = dirE; v.stepsE = stepsE;
      vecs.push_back(v);
   endfunction

   // Position of a pin pair along the up sequence 00 -> 10 -> 11 -> 01
   function automatic int grayPos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] abAt(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   function automatic int modelStep(input int c, input bit up, input int maxv, input bit sat);
      if (sat) return up ? ((c < maxv) ? c + 1 : maxv) : ((c > 0) ? c - 1 : 0);
      return up ? (c + 1) % (maxv + 1) : (c + maxv) % (maxv + 1);
   endfunction

   // Safety net against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   // Main test sequence
   initial begin
      int         kind, p, delta, expSteps, mCnt0, mCnt1, lv;
      logic [1:0] md, newAb;
      bit         sel, up, ill, mDir, mErr;

      rstn = 1'b1; loadEn = 1'b0; loadVal = '0; clrErr = 1'b0;
      pinA = 1'b1; pinB = 1'b1; modeV = 2'b11; curAb = 2'b11;
      #1 rstn = 1'b0;
      $display("[TB] reset and priming with pins at 11");
      startWindow();
      repeat (3) tick();
      checkOutput("rst count", int'(bus0.count), 0);
      checkOutput("rst step", int'(bus0.step), 0);
      checkOutput("rst dir", int'(bus0.dir), 1);
      checkOutput("rst err", int'(bus0.err), 0);
      checkOutput("rst a_db", int'(bus0.a_db), 0);
      checkOutput("rst b_db", int'(bus0.b_db), 0);
      rstn = 1'b1;
      tick(); tick();
      checkOutput("prime a_db early", int'(bus0.a_db), 0);
      tick();
      checkOutput("prime a_db", int'(bus0.a_db), 1);
      checkOutput("prime b_db", int'(bus0.b_db), 1);
      checkOutput("prime dut1 a_db", int'(bus1.a_db), 1);
      startWindow();
      repeat (HOLD) tick();
      checkOutput("prime steps", steps0 + steps1, 0);
      checkOutput("prime err", int'(bus0.err) + int'(bus1.err), 0);
      checkOutput("prime count", int'(bus0.count), 0);

      $display("[TB] load colliding with a step");
      applyStimulus(2'b01, 2'b11);
      repeat (3 + DB) tick();
      loadEn = 1'b1; loadVal = 8'd100;
      tick();
      loadEn = 1'b0;
      checkOutput("load count0", int'(bus0.count), 100);
      checkOutput("load count1", int'(bus1.count), 4);
      checkOutput("load step", int'(bus0.step), 0);
      repeat (5) tick();
      checkOutput("load steps", steps0, 0);
      checkOutput("load dir", int'(bus0.dir), 1);

      $display("[TB] asynchronous reset mid-debounce");
      applyStimulus(2'b00, 2'b11);
      repeat (3) tick();
      #2 rstn = 1'b0;
      #1;
      checkOutput("arst count", int'(bus0.count), 0);
      checkOutput("arst b_db", int'(bus0.b_db), 0);
      checkOutput("arst dir", int'(bus0.dir), 1);
      tick();
      rstn = 1'b1;
      repeat (5) tick();

      $display("[TB] table of x4 up, x1 down and x2 down sequences");
      for (int c = 0; c < 3; c++) begin
         addVec(2'b10, 2'b11, 4 * c + 1, 1'b1, 1);
         addVec(2'b11, 2'b11, 4 * c + 2, 1'b1, 1);
         addVec(2'b01, 2'b11, 4 * c + 3, 1'b1, 1);
         addVec(2'b00, 2'b11, 4 * c + 4, 1'b1, 1);
      end
      addVec(2'b01, 2'b00, 12, 1'b1, 0);
      addVec(2'b11, 2'b00, 11, 1'b0, 1);
      addVec(2'b10, 2'b00, 11, 1'b0, 0);
      addVec(2'b00, 2'b00, 11, 1'b0, 0);
      addVec(2'b01, 2'b01, 11, 1'b0, 0);
      addVec(2'b11, 2'b01, 10, 1'b0, 1);
      addVec(2'b10, 2'b01, 10, 1'b0, 0);
      addVec(2'b00, 2'b01, 10, 1'b0, 0);
      for (int c = 0; c < 2; c++) begin
         addVec(2'b01, 2'b10, 10 - 2 * c, 1'b0, 0);
         addVec(2'b11, 2'b10, 9 - 2 * c, 1'b0, 1);
         addVec(2'b10, 2'b10, 9 - 2 * c, 1'b0, 0);
         addVec(2'b00, 2'b10, 8 - 2 * c, 1'b0, 1);
      end
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ab, vecs[i].md);
         repeat (HOLD) tick();
         checkOutput($sformatf("vec%0d count0", i), int'(bus0.count), vecs[i].cnt);
         checkOutput($sformatf("vec%0d count1", i), int'(bus1.count), vecs[i].cnt);
         checkOutput($sformatf("vec%0d dir", i), int'(bus0.dir), int'(vecs[i].dirE));
         checkOutput($sformatf("vec%0d steps", i), steps0, vecs[i].stepsE);
         if (vecs[i].stepsE == 1) checkOutput($sformatf("vec%0d latency", i), firstChg, 3 + DB);
      end

      $display("[TB] wrap and saturate at the limits");
      modeV = 2'b11;
      loadEn = 1'b1; loadVal = 8'd255;
      tick();
      loadEn = 1'b0;
      checkOutput("top load0", int'(bus0.count), 255);
      checkOutput("top load1 clamp", int'(bus1.count), 23);
      applyStimulus(2'b10, 2'b11);
      repeat (HOLD) tick();
      checkOutput("wrap up count0", int'(bus0.count), 0);
      checkOutput("sat up count1", int'(bus1.count), 23);
      checkOutput("sat up steps1", steps1, 1);
      checkOutput("wrap up dir", int'(bus0.dir), 1);
      loadEn = 1'b1; loadVal = 8'd0;
      tick();
      loadEn = 1'b0;
      applyStimulus(2'b00, 2'b11);
      repeat (HOLD) tick();
      checkOutput("wrap down count0", int'(bus0.count), 255);
      checkOutput("sat down count1", int'(bus1.count), 0);
      checkOutput("sat down steps1", steps1, 1);
      checkOutput("sat down dir", int'(bus1.dir), 0);

      $display("[TB] glitch rejection");
      startWindow();
      pinA = 1'b1;
      repeat (DB - 1) tick();
      pinA = 1'b0;
      repeat (12) tick();
      checkOutput("short glitch a_db", int'(aHigh), 0);
      checkOutput("short glitch steps", steps0, 0);
      startWindow();
      pinA = 1'b1;
      repeat (DB + 1) tick();
      pinA = 1'b0;
      repeat (20) tick();
      checkOutput("long pulse a_db", int'(aHigh), 1);
      checkOutput("long pulse steps0", steps0, 2);
      checkOutput("long pulse steps1", steps1, 2);
      checkOutput("long pulse count0", int'(bus0.count), 255);

      $display("[TB] illegal transitions and error clear");
      applyStimulus(2'b11, 2'b11);
      repeat (HOLD) tick();
      checkOutput("illegal err0", int'(bus0.err), 1);
      checkOutput("illegal err1", int'(bus1.err), 1);
      checkOutput("illegal count0", int'(bus0.count), 255);
      checkOutput("illegal steps", steps0, 0);
      clrErr = 1'b1;
      tick();
      clrErr = 1'b0;
      checkOutput("clr err", int'(bus0.err), 0);
      applyStimulus(2'b00, 2'b11);
      repeat (3 + DB) tick();
      clrErr = 1'b1;
      tick();
      clrErr = 1'b0;
      checkOutput("clr with illegal err", int'(bus0.err), 1);
      repeat (3) tick();
      checkOutput("clr with illegal count", int'(bus0.count), 255);

      $display("[TB] randomized walk against the reference model");
      applyStimulus(2'b00, 2'b11);
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      repeat (5) tick();
      mCnt0 = 0; mCnt1 = 0; mDir = 1'b1; mErr = 1'b0;
      for (int w = 0; w < 40; w++) begin
         kind = $urandom_range(0, 9);
         md = 2'($urandom_range(0, 3));
         expSteps = 0;
         if (kind <= 6) begin
            p = grayPos(curAb);
            if (kind == 6) newAb = abAt(p + 2);
            else newAb = abAt(p + (($urandom_range(0, 1) == 1) ? 1 : 3));
            delta = (grayPos(newAb) - grayPos(curAb) + 4) % 4;
            ill = (delta == 2);
            up  = (delta == 1);
            if (ill) sel = 1'b0;
            else if (md == 2'b11) sel = 1'b1;
            else if (md == 2'b10) sel = (newAb[1] != curAb[1]);
            else sel = (!curAb[1] && newAb[1]);
            applyStimulus(newAb, md);
            repeat (HOLD) tick();
            if (ill) mErr = 1'b1;
            if (sel) begin
               mCnt0 = modelStep(mCnt0, up, MAX0, 1'b0);
               mCnt1 = modelStep(mCnt1, up, MAX1, 1'b1);
               mDir = up;
               expSteps = 1;
            end
         end else if (kind == 7) begin
            applyStimulus(curAb, md);
            lv = $urandom_range(0, 255);
            loadVal = 8'(lv);
            loadEn = 1'b1;
            tick();
            loadEn = 1'b0;
            repeat (HOLD - 1) tick();
            mCnt0 = lv;
            mCnt1 = ((lv % 32) > MAX1) ? MAX1 : (lv % 32);
         end else if (kind == 8) begin
            applyStimulus(curAb, md);
            clrErr = 1'b1;
            tick();
            clrErr = 1'b0;
            repeat (HOLD - 1) tick();
            mErr = 1'b0;
         end else begin
            applyStimulus(curAb, md);
            repeat (HOLD) tick();
         end
         checkOutput($sformatf("rnd%0d count0", w), int'(bus0.count), mCnt0);
         checkOutput($sformatf("rnd%0d count1", w), int'(bus1.count), mCnt1);
         checkOutput($sformatf("rnd%0d dir", w), int'(bus0.dir), int'(mDir));
         checkOutput($sformatf("rnd%0d err0", w), int'(bus0.err), int'(mErr));
         checkOutput($sformatf("rnd%0d err1", w), int'(bus1.err), int'(mErr));
         checkOutput($sformatf("rnd%0d steps0", w), steps0, expSteps);
         checkOutput($sformatf("rnd%0d steps1", w), steps1, expSteps);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
